// File: rtl/scan_sequencer.sv
// Two-dimensional affine address scan: one descriptor in, x_max*y_max addresses out, then a one-cycle done pulse.
// First address one cycle after acceptance, one address per cycle; addr/addr_last/counters hold while addr_ready is low.
module scan_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_offset,
   input  logic [WIDTH-1:0] cfg_x_max,
   input  logic [WIDTH-1:0] cfg_y_max,
   input  logic [WIDTH-1:0] cfg_x_stride,
   input  logic [WIDTH-1:0] cfg_y_stride,
   input  logic             abort,
   output logic             addr_valid,
   input  logic             addr_ready,
   output logic [WIDTH-1:0] addr,
   output logic             addr_last,
   output logic             done,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef struct packed {
      logic [WIDTH-1:0] x_max;
      logic [WIDTH-1:0] y_max;
      logic [WIDTH-1:0] x_stride;
      logic [WIDTH-1:0] y_stride;
   } desc_t;

   logic [1:0]       state;
   desc_t            desc;
   logic [WIDTH-1:0] x_cnt;
   logic [WIDTH-1:0] y_cnt;
   logic             x_wrap;
   logic             y_wrap;
   logic             beat;

   assign x_wrap = (x_cnt == desc.x_max - WIDTH'(1));
   assign y_wrap = (y_cnt == desc.y_max - WIDTH'(1));

   // Every output is a decode of registered state; nothing flows through from addr_ready or cfg_valid.
   assign cfg_ready  = (state == IDLE);
   assign addr_valid = (state == RUN);
   assign done       = (state == DONE);
   assign busy       = (state != IDLE);
   assign addr_last  = addr_valid && x_wrap && y_wrap;
   assign beat       = addr_valid && addr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         desc  <= '0;
         addr  <= '0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  desc.x_max    <= cfg_x_max;
                  desc.y_max    <= cfg_y_max;
                  desc.x_stride <= cfg_x_stride;
                  desc.y_stride <= cfg_y_stride;
                  addr          <= cfg_offset;
                  x_cnt         <= '0;
                  y_cnt         <= '0;
                  state         <= (cfg_x_max == '0 || cfg_y_max == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // Abort wins over a same-cycle beat: the consumer keeps it, nothing further is emitted.
               if (abort) begin
                  state <= IDLE;
                  desc  <= '0;
                  addr  <= '0;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end else if (beat) begin
                  if (addr_last)
                     state <= DONE;
                  if (x_wrap) begin
                     addr  <= addr + desc.y_stride;
                     x_cnt <= '0;
                     y_cnt <= y_cnt + WIDTH'(1);
                  end else begin
                     addr  <= addr + desc.x_stride;
                     x_cnt <= x_cnt + WIDTH'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               if (abort) begin
                  desc  <= '0;
                  addr  <= '0;
                  x_cnt <= '0;
                  y_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: hand-computed address sequences, handshakes, abort and reset.
module tb_scan_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_offset;
   logic [15:0] cfg_x_max;
   logic [15:0] cfg_y_max;
   logic [15:0] cfg_x_stride;
   logic [15:0] cfg_y_stride;
   logic        abort;
   logic        addr_valid;
   logic        addr_ready;
   logic [15:0] addr;
   logic        addr_last;
   logic        done;
   logic        busy;

   int vecs;
   int errs;

   scan_sequencer #(.WIDTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_offset   (cfg_offset),
      .cfg_x_max    (cfg_x_max),
      .cfg_y_max    (cfg_y_max),
      .cfg_x_stride (cfg_x_stride),
      .cfg_y_stride (cfg_y_stride),
      .abort        (abort),
      .addr_valid   (addr_valid),
      .addr_ready   (addr_ready),
      .addr         (addr),
      .addr_last    (addr_last),
      .done         (done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a descriptor for one cycle; returns in the cycle after acceptance.
   task automatic send(input logic [15:0] off, input logic [15:0] xm, input logic [15:0] ym,
                       input logic [15:0] xs, input logic [15:0] ys);
      cfg_offset   = off;
      cfg_x_max    = xm;
      cfg_y_max    = ym;
      cfg_x_stride = xs;
      cfg_y_stride = ys;
      cfg_valid    = 1'b1;
      chk("send_cfg_ready", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [15:0] a, input logic last);
      chk({tag, "_valid"}, addr_valid, 1);
      chk({tag, "_addr"}, addr, a);
      chk({tag, "_last"}, addr_last, last);
   endtask

   task automatic chk_done_then_idle(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_done_cfg_ready"}, cfg_ready, 0);
      chk({tag, "_done_busy"}, busy, 1);
      chk({tag, "_done_valid"}, addr_valid, 0);
      tick();
      chk({tag, "_idle_done"}, done, 0);
      chk({tag, "_idle_cfg_ready"}, cfg_ready, 1);
      chk({tag, "_idle_busy"}, busy, 0);
   endtask

   logic [15:0] basic_exp [6];
   logic [11:0] rdy_pat;

   initial begin
      int idx;
      vecs = 0;
      errs = 0;
      basic_exp[0] = 16'd100; basic_exp[1] = 16'd104; basic_exp[2] = 16'd108;
      basic_exp[3] = 16'd128; basic_exp[4] = 16'd132; basic_exp[5] = 16'd136;
      rdy_pat = 12'b1101_0101_1001;  // consumed LSB first: 1,0,0,1,1,0,1,0,1,0,1,1

      rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; addr_ready = 1'b0;
      cfg_offset = '0; cfg_x_max = '0; cfg_y_max = '0; cfg_x_stride = '0; cfg_y_stride = '0;
      #2;
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_valid", addr_valid, 0);
      chk("rst_addr", addr, 0);
      chk("rst_last", addr_last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic scan at full throughput.
      addr_ready = 1'b1;
      send(16'd100, 16'd3, 16'd2, 16'd4, 16'd20);
      for (int i = 0; i < 6; i++) begin
         chk_beat($sformatf("basic%0d", i), basic_exp[i], i == 5);
         chk("basic_busy", busy, 1);
         tick();
      end
      chk_done_then_idle("basic");

      // Backpressure: stalled cycles must show the same address again.
      addr_ready = 1'b0;
      send(16'd100, 16'd3, 16'd2, 16'd4, 16'd20);
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         addr_ready = (c < 12) ? rdy_pat[c] : 1'b1;
         chk_beat($sformatf("bp%0d", c), basic_exp[idx], idx == 5);
         if (addr_ready) idx++;
         tick();
      end
      chk("bp_all_beats", idx, 6);
      chk_done_then_idle("bp");

      // Zero dimensions: straight to done, no address.
      addr_ready = 1'b1;
      send(16'd50, 16'd0, 16'd4, 16'd1, 16'd1);
      chk("zx_valid", addr_valid, 0);
      chk_done_then_idle("zx");
      send(16'd50, 16'd4, 16'd0, 16'd1, 16'd1);
      chk("zy_valid", addr_valid, 0);
      chk_done_then_idle("zy");

      // Wrap-around modulo 2^16.
      send(16'hFFF0, 16'd2, 16'd1, 16'h0020, 16'h0000);
      chk_beat("wrap0", 16'hFFF0, 1'b0);
      tick();
      chk_beat("wrap1", 16'h0010, 1'b1);
      tick();
      chk_done_then_idle("wrap");

      // Abort on the second beat.
      send(16'd100, 16'd3, 16'd2, 16'd4, 16'd20);
      chk_beat("ab0", 16'd100, 1'b0);
      tick();
      chk_beat("ab1", 16'd104, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_cfg_ready", cfg_ready, 1);
      chk("ab_valid", addr_valid, 0);
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 0);
      tick();
      chk("ab_no_done", done, 0);
      // Abort in IDLE is ignored and the descriptor is still taken.
      abort = 1'b1;
      send(16'd7, 16'd2, 16'd1, 16'd1, 16'd0);
      abort = 1'b0;
      chk_beat("ab_new0", 16'd7, 1'b0);
      tick();
      chk_beat("ab_new1", 16'd8, 1'b1);
      tick();
      chk_done_then_idle("ab_new");

      // Asynchronous reset mid-scan.
      send(16'd100, 16'd3, 16'd2, 16'd4, 16'd20);
      tick();
      tick();
      chk_beat("rs_pre", 16'd108, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rs_cfg_ready", cfg_ready, 1);
      chk("rs_valid", addr_valid, 0);
      chk("rs_addr", addr, 0);
      chk("rs_last", addr_last, 0);
      chk("rs_done", done, 0);
      chk("rs_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Back-to-back descriptors; the second is held valid with new fields during the first scan.
      send(16'd5, 16'd1, 16'd1, 16'd3, 16'd3);
      cfg_offset = 16'd9;
      cfg_valid  = 1'b1;
      chk_beat("b2b_a", 16'd5, 1'b1);
      chk("b2b_a_cfg_ready", cfg_ready, 0);
      tick();
      chk("b2b_a_done", done, 1);
      chk("b2b_a_done_valid", addr_valid, 0);
      tick();
      chk("b2b_accept_cfg_ready", cfg_ready, 1);
      chk("b2b_gap_valid", addr_valid, 0);
      tick();
      cfg_valid = 1'b0;
      chk_beat("b2b_b", 16'd9, 1'b1);
      tick();
      chk_done_then_idle("b2b_b");
      chk("b2b_end_valid", addr_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
